// File: rtl/shift_reg_param.sv
// Parametrised universal shift register: left/right shift, parallel load, hold,
// serial output, saturating fill count and fixed-pattern detect.
module shift_reg_param #(
    parameter int                 WIDTH   = 4,
    parameter logic [WIDTH-1:0]   PATTERN = 4'b1011
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           En,
    input  logic [1:0]                     Mode,
    input  logic                           D,
    input  logic [WIDTH-1:0]               Load,
    output logic [WIDTH-1:0]               Q,
    output logic                           SerOut,
    output logic [$clog2(WIDTH+1)-1:0]     Count,
    output logic                           Full,
    output logic                           Match
);

    localparam int              CW         = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   FULL_COUNT = CW'(WIDTH);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LEFT  = 2'b01;
    localparam logic [1:0] MODE_RIGHT = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [CW-1:0] count_next_shift;

    // Once full, further shifts keep the count pinned at WIDTH rather than wrapping.
    assign count_next_shift = Full ? Count : Count + CW'(1);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Q     <= '0;
            Count <= '0;
        end else if (En) begin
            case (Mode)
                MODE_LEFT: begin
                    Q     <= {Q[WIDTH-2:0], D};
                    Count <= count_next_shift;
                end
                MODE_RIGHT: begin
                    Q     <= {D, Q[WIDTH-1:1]};
                    Count <= count_next_shift;
                end
                MODE_LOAD: begin
                    Q     <= Load;
                    Count <= FULL_COUNT;
                end
                default: begin
                    Q     <= Q;
                    Count <= Count;
                end
            endcase
        end
    end

    // SerOut shows the bit the next shift in the selected direction would drop.
    assign SerOut = (Mode == MODE_LEFT) ? Q[WIDTH-1] : Q[0];
    assign Full   = (Count == FULL_COUNT);
    assign Match  = Full && (Q == PATTERN);

    logic unused_mode_hold;
    assign unused_mode_hold = (Mode == MODE_HOLD);

endmodule

// File: tb/tb_shift_reg_param.sv
// Bench for shift_reg_param (WIDTH=4): directed vector table, hand-written
// corner sequences and random stimulus against an arithmetic reference model.
module tb_shift_reg_param;

    localparam int WIDTH = 4;
    localparam int PAT   = 11;

    logic       Clk = 1'b0;
    logic       Reset, En, D;
    logic [1:0] Mode;
    logic [3:0] Load;
    logic [3:0] Q, Q_z;
    logic       SerOut, SerOut_z;
    logic [2:0] Count, Count_z;
    logic       Full, Full_z, Match, Match_z;

    int n_pass  = 0;
    int n_total = 0;
    int m_q     = 0;
    int m_count = 0;

    shift_reg_param #(.WIDTH(4), .PATTERN(4'b1011)) u_dut (
        .Clk(Clk), .Reset(Reset), .En(En), .Mode(Mode), .D(D), .Load(Load),
        .Q(Q), .SerOut(SerOut), .Count(Count), .Full(Full), .Match(Match)
    );

    shift_reg_param #(.WIDTH(4), .PATTERN(4'b0000)) u_zero (
        .Clk(Clk), .Reset(Reset), .En(En), .Mode(Mode), .D(D), .Load(Load),
        .Q(Q_z), .SerOut(SerOut_z), .Count(Count_z), .Full(Full_z), .Match(Match_z)
    );

    always #100 Clk = ~Clk;

    typedef struct {
        bit       rst;
        bit       en;
        bit [1:0] mode;
        bit       d;
        bit [3:0] load;
        bit [3:0] q;
        int       cnt;
        bit       full;
        bit       match;
        bit       so;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_update(input bit en, input bit [1:0] mode, input bit d, input bit [3:0] load);
        if (en) begin
            case (mode)
                2'd1: begin
                    m_q     = (m_q * 2 + int'(d)) % 16;
                    m_count = (m_count < WIDTH) ? m_count + 1 : WIDTH;
                end
                2'd2: begin
                    m_q     = m_q / 2 + int'(d) * 8;
                    m_count = (m_count < WIDTH) ? m_count + 1 : WIDTH;
                end
                2'd3: begin
                    m_q     = int'(load);
                    m_count = WIDTH;
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_model(input string tag);
        int full;
        int so;
        full = (m_count == WIDTH) ? 1 : 0;
        so   = (Mode == 2'd1) ? (m_q / 8) % 2 : m_q % 2;
        chk({tag, " q"},       int'(Q),       m_q);
        chk({tag, " count"},   int'(Count),   m_count);
        chk({tag, " full"},    int'(Full),    full);
        chk({tag, " match"},   int'(Match),   (full == 1 && m_q == PAT) ? 1 : 0);
        chk({tag, " serout"},  int'(SerOut),  so);
        chk({tag, " zmatch"},  int'(Match_z), (full == 1 && m_q == 0) ? 1 : 0);
    endtask

    task automatic step(input bit en, input bit [1:0] mode, input bit d, input bit [3:0] load);
        En = en; Mode = mode; D = d; Load = load;
        @(posedge Clk);
        model_update(en, mode, d, load);
        #1;
    endtask

    // Pulse reset between edges; state must clear without any clock edge.
    task automatic reset_pulse(input string tag);
        #10 Reset = 1'b1;
        m_q = 0; m_count = 0;
        #20 check_model(tag);
        #10 Reset = 1'b0;
        #5;
    endtask

    initial begin
        bit dseq[4];
        Reset = 1'b1; En = 1'b0; Mode = 2'd0; D = 1'b0; Load = 4'd0;
        #30 check_model("por");
        #20 Reset = 1'b0;

        //            rst en mode d  load    q       cnt full match so
        vecs.push_back('{0, 1, 2'd1, 1, 4'h0, 4'b0001, 1, 0, 0, 0});
        vecs.push_back('{0, 1, 2'd1, 0, 4'h0, 4'b0010, 2, 0, 0, 0});
        vecs.push_back('{0, 1, 2'd1, 1, 4'h0, 4'b0101, 3, 0, 0, 0});
        vecs.push_back('{0, 1, 2'd1, 1, 4'h0, 4'b1011, 4, 1, 1, 1});
        vecs.push_back('{0, 1, 2'd1, 0, 4'h0, 4'b0110, 4, 1, 0, 0});
        vecs.push_back('{1, 0, 2'd1, 0, 4'h0, 4'b0000, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 2'd2, 1, 4'h0, 4'b1000, 1, 0, 0, 0});
        vecs.push_back('{0, 1, 2'd2, 1, 4'h0, 4'b1100, 2, 0, 0, 0});
        vecs.push_back('{0, 1, 2'd2, 0, 4'h0, 4'b0110, 3, 0, 0, 0});
        vecs.push_back('{0, 1, 2'd2, 0, 4'h0, 4'b0011, 4, 1, 0, 1});
        vecs.push_back('{0, 1, 2'd3, 0, 4'hB, 4'b1011, 4, 1, 1, 1});
        vecs.push_back('{0, 0, 2'd1, 1, 4'h5, 4'b1011, 4, 1, 1, 1});
        vecs.push_back('{0, 0, 2'd1, 0, 4'h5, 4'b1011, 4, 1, 1, 1});
        vecs.push_back('{0, 0, 2'd1, 1, 4'h5, 4'b1011, 4, 1, 1, 1});
        vecs.push_back('{0, 1, 2'd0, 0, 4'h5, 4'b1011, 4, 1, 1, 1});
        vecs.push_back('{1, 0, 2'd0, 0, 4'h0, 4'b0000, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 2'd1, 1, 4'h0, 4'b0001, 1, 0, 0, 0});
        vecs.push_back('{0, 1, 2'd2, 1, 4'h0, 4'b1000, 2, 0, 0, 0});
        vecs.push_back('{0, 1, 2'd1, 1, 4'h0, 4'b0001, 3, 0, 0, 0});

        foreach (vecs[i]) begin
            vec_t v;
            string tag;
            v = vecs[i];
            tag = $sformatf("vec%0d", i);
            if (v.rst) begin
                Mode = v.mode;
                #10 Reset = 1'b1;
                m_q = 0; m_count = 0;
                #20;
            end else begin
                step(v.en, v.mode, v.d, v.load);
            end
            chk({tag, " q"},      int'(Q),      int'(v.q));
            chk({tag, " count"},  int'(Count),  v.cnt);
            chk({tag, " full"},   int'(Full),   int'(v.full));
            chk({tag, " match"},  int'(Match),  int'(v.match));
            chk({tag, " serout"}, int'(SerOut), int'(v.so));
            if (v.rst) begin
                #10 Reset = 1'b0;
                #5;
            end
        end

        // Asynchronous reset clears a loaded register before the next edge.
        step(1, 2'd3, 0, 4'hF);
        chk("load 1111 q", int'(Q), 15);
        #20 Reset = 1'b1;
        m_q = 0; m_count = 0;
        #25;
        chk("async q",     int'(Q),     0);
        chk("async count", int'(Count), 0);
        chk("async full",  int'(Full),  0);
        chk("async match", int'(Match), 0);
        #25 Reset = 1'b0;
        #5 chk("after release q", int'(Q), 0);

        // Reset mid-sequence discards the partial word.
        step(1, 2'd1, 1, 4'h0);
        step(1, 2'd1, 1, 4'h0);
        chk("mid count before reset", int'(Count), 2);
        reset_pulse("mid reset");
        dseq[0] = 1'b1; dseq[1] = 1'b0; dseq[2] = 1'b1; dseq[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1, 2'd1, dseq[i], 4'h0);
            chk($sformatf("mid count %0d", i), int'(Count), i + 1);
            chk($sformatf("mid match %0d", i), int'(Match), (i == 3) ? 1 : 0);
        end

        // Zero pattern must not match until the register is full.
        reset_pulse("zero reset");
        chk("zero match at reset", int'(Match_z), 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 2'd1, 0, 4'h0);
            chk($sformatf("zero q %0d", i),     int'(Q_z),     0);
            chk($sformatf("zero match %0d", i), int'(Match_z), (i == 3) ? 1 : 0);
        end
        step(1, 2'd1, 1, 4'h0);
        chk("zero match after 1", int'(Match_z), 0);

        // Random stimulus against the reference model.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset_pulse($sformatf("rnd%0d reset", n));
            end else begin
                step(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
                check_model($sformatf("rnd%0d", n));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
